// File: rtl/sprite_line_renderer_pkg.sv
// Shared constants and types for the sprite line renderer and its slot buffer.
package sprite_line_renderer_pkg;

  localparam int SPRITE_SIZE     = 8;
  localparam int SPRITE_ID_W     = 4;
  localparam int DEFAULT_COORD_W = 10;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'd0,
    ORIENT_RIGHT = 2'd1,
    ORIENT_DOWN  = 2'd2,
    ORIENT_LEFT  = 2'd3
  } orientation_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_renderer_slot.sv
// One slot of the scanline sprite buffer: holds a captured sprite row and
// reports whether the current pixel column lands on one of its lit pixels.
module sprite_slot
  import sprite_line_renderer_pkg::*;
#(
  parameter int COORD_W = DEFAULT_COORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [COORD_W-1:0]     load_x,
  input  logic [SPRITE_ID_W-1:0] load_id,
  input  logic [7:0]             load_bitmap,
  input  logic [COORD_W-1:0]     pixel_x,
  output logic                   slot_hit,
  output logic [SPRITE_ID_W-1:0] slot_id
);

  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SPRITE_SIZE);

  logic                   valid_q;
  logic [COORD_W-1:0]     x_q;
  logic [SPRITE_ID_W-1:0] id_q;
  logic [7:0]             bitmap_q;
  logic [COORD_W:0]       col;
  logic [2:0]             bit_sel;
  logic                   in_range;

  // Slot registers: cleared at the start of every line, loaded once per captured sprite
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      x_q      <= '0;
      id_q     <= '0;
      bitmap_q <= '0;
    end else if (clear) begin
      valid_q  <= 1'b0;
      x_q      <= '0;
      id_q     <= '0;
      bitmap_q <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      x_q      <= load_x;
      id_q     <= load_id;
      bitmap_q <= load_bitmap;
    end
  end

  // Column within the sprite, one bit wider so pixels left of the sprite never alias
  assign col      = {1'b0, pixel_x} - {1'b0, x_q};
  assign in_range = (pixel_x >= x_q) && (col < SIZE_EXT);
  assign bit_sel  = 3'(SPRITE_SIZE - 1) - col[2:0];
  assign slot_hit = valid_q && in_range && !bitmap_q[bit_sel];
  assign slot_id  = id_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// Scans the entity table during hblank, fetches rows of sprites that cross the
// next scanline into a slot buffer, then resolves per-pixel sprite hits.
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_SLOTS   = 4,
  parameter int COORD_W     = DEFAULT_COORD_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           line_start,
  input  logic [COORD_W-1:0]             target_y,
  output logic [$clog2(NUM_ENTRIES)-1:0] entry_index,
  input  logic                           entry_valid,
  input  logic [SPRITE_ID_W-1:0]         entry_sprite_ID,
  input  logic [1:0]                     entry_orientation,
  input  logic [COORD_W-1:0]             entry_x,
  input  logic [COORD_W-1:0]             entry_y,
  output logic                           rom_read_enable,
  output logic [1:0]                     rom_orientation,
  output logic [SPRITE_ID_W-1:0]         rom_sprite_ID,
  output logic [2:0]                     rom_line_index,
  input  logic [7:0]                     rom_data,
  input  logic [COORD_W-1:0]             pixel_x,
  input  logic                           pixel_valid,
  output logic                           pixel_on,
  output logic [SPRITE_ID_W-1:0]         pixel_sprite_ID,
  output logic                           fetch_done,
  output logic                           overflow
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  fetch_state_t           state;
  logic [COORD_W-1:0]     target_y_q;
  logic [CNT_W-1:0]       fill_count;
  logic [COORD_W-1:0]     row;
  logic                   hit;
  logic                   reading;
  logic                   capture;
  logic                   room;
  logic [NUM_SLOTS-1:0]   slot_load;
  logic [NUM_SLOTS-1:0]   slot_hit;
  logic [SPRITE_ID_W-1:0] slot_id [NUM_SLOTS];
  logic                   win_hit;
  logic [SPRITE_ID_W-1:0] win_id;

  // Row of the current entry that falls on the target line; wraps modulo 2^COORD_W
  assign row     = target_y_q - entry_y;
  assign hit     = entry_valid && (row < COORD_W'(SPRITE_SIZE));
  assign reading = (state == ST_FETCH) && hit;

  assign rom_read_enable = reading;
  assign rom_line_index  = reading ? row[2:0] : 3'd0;
  assign rom_orientation = reading ? entry_orientation : 2'd0;
  assign rom_sprite_ID   = reading ? entry_sprite_ID : '0;

  // A restart on line_start wins over capturing the entry in the same cycle
  assign capture = reading && !line_start;
  assign room    = fill_count < CNT_W'(NUM_SLOTS);

  // Route the capture to the lowest free slot so slots fill in entry order
  always_comb begin
    slot_load = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_load[i] = capture && room && (fill_count == CNT_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_slot #(
      .COORD_W(COORD_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .clear       (line_start),
      .load        (slot_load[g]),
      .load_x      (entry_x),
      .load_id     (entry_sprite_ID),
      .load_bitmap (rom_data),
      .pixel_x     (pixel_x),
      .slot_hit    (slot_hit[g]),
      .slot_id     (slot_id[g])
    );
  end

  // Priority encoder: walking downward leaves the lowest hitting slot as winner
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        win_hit = 1'b1;
        win_id  = slot_id[i];
      end
    end
  end

  // Fetch sequencer: one table entry per cycle, restartable by line_start at any time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      entry_index <= '0;
      target_y_q  <= '0;
      fill_count  <= '0;
      fetch_done  <= 1'b0;
      overflow    <= 1'b0;
    end else if (line_start) begin
      state       <= ST_FETCH;
      entry_index <= '0;
      target_y_q  <= target_y;
      fill_count  <= '0;
      fetch_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (capture) begin
            if (room) begin
              fill_count <= fill_count + CNT_W'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
          entry_index <= entry_index + IDX_W'(1);
          if (entry_index == IDX_W'(NUM_ENTRIES - 1)) begin
            state      <= ST_DONE;
            fetch_done <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // Pixel output stage: one cycle behind pixel_x, blanked outside active video or before fetch completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_on        <= 1'b0;
      pixel_sprite_ID <= '0;
    end else begin
      pixel_on        <= pixel_valid && fetch_done && win_hit;
      pixel_sprite_ID <= win_id;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer: directed scenarios plus random
// lines, compared every cycle against a line-level behavioural model.
module tb_sprite_line_renderer;
  import sprite_line_renderer_pkg::*;

  localparam int NUM_ENTRIES = 8;
  localparam int NUM_SLOTS   = 4;
  localparam int COORD_W     = 10;
  localparam int IDX_W       = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               line_start = 1'b0;
  logic [COORD_W-1:0] target_y = '0;
  logic [IDX_W-1:0]   entry_index;
  logic               entry_valid;
  logic [3:0]         entry_sprite_ID;
  logic [1:0]         entry_orientation;
  logic [COORD_W-1:0] entry_x;
  logic [COORD_W-1:0] entry_y;
  logic               rom_read_enable;
  logic [1:0]         rom_orientation;
  logic [3:0]         rom_sprite_ID;
  logic [2:0]         rom_line_index;
  logic [7:0]         rom_data;
  logic [COORD_W-1:0] pixel_x = '0;
  logic               pixel_valid = 1'b0;
  logic               pixel_on;
  logic [3:0]         pixel_sprite_ID;
  logic               fetch_done;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  // Entity table and sprite ROM, both answering combinationally
  logic               tbl_valid [NUM_ENTRIES];
  logic [3:0]         tbl_id    [NUM_ENTRIES];
  logic [1:0]         tbl_or    [NUM_ENTRIES];
  logic [COORD_W-1:0] tbl_x     [NUM_ENTRIES];
  logic [COORD_W-1:0] tbl_y     [NUM_ENTRIES];
  logic [7:0]         rom_mem   [512];

  assign entry_valid       = tbl_valid[entry_index];
  assign entry_sprite_ID   = tbl_id[entry_index];
  assign entry_orientation = tbl_or[entry_index];
  assign entry_x           = tbl_x[entry_index];
  assign entry_y           = tbl_y[entry_index];
  assign rom_data          = rom_mem[{rom_sprite_ID, rom_orientation, rom_line_index}];

  always #5 clk = ~clk;

  sprite_line_renderer #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .NUM_SLOTS  (NUM_SLOTS),
    .COORD_W    (COORD_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .line_start       (line_start),
    .target_y         (target_y),
    .entry_index      (entry_index),
    .entry_valid      (entry_valid),
    .entry_sprite_ID  (entry_sprite_ID),
    .entry_orientation(entry_orientation),
    .entry_x          (entry_x),
    .entry_y          (entry_y),
    .rom_read_enable  (rom_read_enable),
    .rom_orientation  (rom_orientation),
    .rom_sprite_ID    (rom_sprite_ID),
    .rom_line_index   (rom_line_index),
    .rom_data         (rom_data),
    .pixel_x          (pixel_x),
    .pixel_valid      (pixel_valid),
    .pixel_on         (pixel_on),
    .pixel_sprite_ID  (pixel_sprite_ID),
    .fetch_done       (fetch_done),
    .overflow         (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: the whole line result is computed at line_start from the table
  int               m_cnt = -1;
  bit               m_done = 1'b0;
  bit               m_ovf = 1'b0;
  int               m_n = 0;
  logic [COORD_W-1:0] m_ty = '0;
  logic [COORD_W-1:0] m_x   [NUM_SLOTS];
  logic [3:0]         m_id  [NUM_SLOTS];
  logic [7:0]         m_bmp [NUM_SLOTS];
  bit               exp_on = 1'b0;
  logic [3:0]       exp_id = '0;
  bit               exp_id_chk = 1'b0;

  function automatic bit row_hit(input int e, input logic [COORD_W-1:0] ty, output logic [2:0] r);
    int d;
    d = (int'(ty) - int'(tbl_y[e]) + (1 << COORD_W)) % (1 << COORD_W);
    r = d[2:0];
    return tbl_valid[e] && (d < 8);
  endfunction

  function automatic void model_pixel(input logic [COORD_W-1:0] px, output bit on, output logic [3:0] id);
    on = 1'b0;
    id = '0;
    for (int s = 0; s < m_n; s++) begin
      int c;
      c = int'(px) - int'(m_x[s]);
      if (!on && c >= 0 && c < 8 && !m_bmp[s][7-c]) begin
        on = 1'b1;
        id = m_id[s];
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    bit         on;
    logic [3:0] id;
    logic [2:0] r;
    if (!reset) begin
      m_cnt = -1; m_done = 1'b0; m_ovf = 1'b0; m_n = 0;
      exp_on = 1'b0; exp_id = '0; exp_id_chk = 1'b0;
    end else begin
      model_pixel(pixel_x, on, id);
      exp_on     = pixel_valid && m_done && on;
      exp_id     = id;
      exp_id_chk = m_done;
      if (line_start) begin
        m_ty = target_y; m_n = 0; m_ovf = 1'b0; m_cnt = 0; m_done = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (row_hit(e, target_y, r)) begin
            if (m_n < NUM_SLOTS) begin
              m_x[m_n]   = tbl_x[e];
              m_id[m_n]  = tbl_id[e];
              m_bmp[m_n] = rom_mem[{tbl_id[e], tbl_or[e], r}];
              m_n++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end else if (m_cnt >= 0 && !m_done) begin
        m_cnt++;
        if (m_cnt == NUM_ENTRIES) m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [2:0] r;
    bit         exp_rd;
    if (!reset) begin
      check("reset_pixel_on", pixel_on, 0);
      check("reset_fetch_done", fetch_done, 0);
    end else begin
      if (m_cnt >= 0 && !m_done) begin
        exp_rd = row_hit(m_cnt, m_ty, r);
        check("entry_index", entry_index, m_cnt);
        check("rom_read_enable", rom_read_enable, exp_rd);
        check("rom_line_index", rom_line_index, exp_rd ? 32'(r) : 32'd0);
        check("rom_sprite_ID", rom_sprite_ID, exp_rd ? 32'(tbl_id[m_cnt]) : 32'd0);
        check("rom_orientation", rom_orientation, exp_rd ? 32'(tbl_or[m_cnt]) : 32'd0);
      end else begin
        check("rom_idle", rom_read_enable, 0);
      end
      check("fetch_done", fetch_done, m_done);
      if (m_done) check("overflow", overflow, m_ovf);
      check("pixel_on", pixel_on, exp_on);
      if (exp_id_chk) check("pixel_sprite_ID", pixel_sprite_ID, exp_id);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [COORD_W-1:0] ty);
    line_start = 1'b1;
    target_y   = ty;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !fetch_done; i++) tick();
    check("fetch_done_timeout", fetch_done, 1);
  endtask

  task automatic clear_table();
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      tbl_valid[e] = 1'b0; tbl_id[e] = '0; tbl_or[e] = '0; tbl_x[e] = '0; tbl_y[e] = '0;
    end
  endtask

  task automatic set_entry(input int e, input logic [3:0] id, input logic [1:0] o,
                           input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    tbl_valid[e] = 1'b1; tbl_id[e] = id; tbl_or[e] = o; tbl_x[e] = x; tbl_y[e] = y;
  endtask

  task automatic probe(input string name, input logic [COORD_W-1:0] px, input bit on, input logic [3:0] id);
    pixel_x = px;
    pixel_valid = 1'b1;
    tick();
    check(name, pixel_on, on);
    if (on) check({name, "_id"}, pixel_sprite_ID, id);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int reads;
    int lit;
    for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);
    rom_mem[{4'd0, 2'd0, 3'd1}] = 8'b10011001;
    clear_table();

    // Reset state
    tick();
    check("rst_entry_index", entry_index, 0);
    check("rst_rom_read_enable", rom_read_enable, 0);
    check("rst_pixel_on", pixel_on, 0);
    check("rst_pixel_sprite_ID", pixel_sprite_ID, 0);
    check("rst_fetch_done", fetch_done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick();

    // Heart sprite, row 1
    set_entry(0, 4'd0, 2'd0, 10'd100, 10'd50);
    apply_stimulus(10'd51);
    check("heart_read", rom_read_enable, 1);
    check("heart_line_index", rom_line_index, 1);
    reads = 0;
    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      tick();
      reads += int'(rom_read_enable);
    end
    check("heart_single_read", reads, 0);
    wait_done();
    probe("heart_x100", 10'd100, 1'b0, 4'd0);
    probe("heart_x101", 10'd101, 1'b1, 4'd0);
    probe("heart_x108", 10'd108, 1'b0, 4'd0);

    // Rows just outside and at the bottom edge of the sprite
    for (int t = 0; t < 2; t++) begin
      apply_stimulus(t == 0 ? 10'd49 : 10'd58);
      reads = int'(rom_read_enable);
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
        tick();
        reads += int'(rom_read_enable);
      end
      check("miss_no_read", reads, 0);
      wait_done();
      lit = 0;
      for (int px = 95; px < 112; px++) begin
        pixel_x = COORD_W'(px); tick(); lit += int'(pixel_on);
      end
      check("miss_no_pixels", lit, 0);
    end
    apply_stimulus(10'd57);
    check("bottom_line_index", rom_line_index, 7);
    wait_done();

    // Five hits with four slots; also exact fetch_done timing
    clear_table();
    for (int e = 0; e < 5; e++) begin
      set_entry(e, 4'(e + 2), 2'(e % 4), e == 4 ? 10'd600 : 10'(50 * e + 10), 10'(200 - e));
    end
    rom_mem[{4'd2, 2'd0, 3'd0}] = 8'h00;
    rom_mem[{4'd6, 2'd0, 3'd4}] = 8'h00;
    apply_stimulus(10'd200);
    for (int i = 1; i < NUM_ENTRIES; i++) tick();
    check("done_not_early", fetch_done, 0);
    tick();
    check("done_on_time", fetch_done, 1);
    check("overflow_set", overflow, 1);
    probe("slot0_entry0", 10'd10, 1'b1, 4'd2);
    lit = 0;
    for (int px = 600; px < 608; px++) begin
      pixel_x = COORD_W'(px); tick(); lit += int'(pixel_on);
    end
    check("dropped_entry4", lit, 0);

    // Restart in the middle of a fetch
    apply_stimulus(10'd200);
    for (int i = 0; i < 3; i++) tick();
    check("restart_at3", entry_index, 3);
    apply_stimulus(10'd200);
    check("restart_index0", entry_index, 0);
    check("restart_done_low", fetch_done, 0);
    for (int i = 1; i < NUM_ENTRIES; i++) tick();
    check("restart_not_early", fetch_done, 0);
    tick();
    check("restart_done", fetch_done, 1);

    // Overlapping sprites: lower entry wins
    clear_table();
    set_entry(2, 4'd1, 2'd0, 10'd300, 10'd400);
    set_entry(5, 4'd7, 2'd0, 10'd300, 10'd400);
    rom_mem[{4'd1, 2'd0, 3'd3}] = 8'h00;
    rom_mem[{4'd7, 2'd0, 3'd3}] = 8'h00;
    apply_stimulus(10'd403);
    wait_done();
    check("overlap_no_overflow", overflow, 0);
    probe("overlap_x303", 10'd303, 1'b1, 4'd1);
    probe("overlap_x308", 10'd308, 1'b0, 4'd0);

    // Asynchronous reset while a sprite is under the pixel
    probe("prereset_on", 10'd300, 1'b1, 4'd1);
    #2 reset = 1'b0;
    #1;
    check("async_pixel_on", pixel_on, 0);
    check("async_fetch_done", fetch_done, 0);
    tick();
    reset = 1'b1;
    lit = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); lit += int'(pixel_on);
    end
    check("post_reset_dark", lit, 0);
    apply_stimulus(10'd403);
    wait_done();
    probe("refetch_on", 10'd301, 1'b1, 4'd1);

    // Random lines with occasional restarts and clipping at the right edge
    for (int n = 0; n < 40; n++) begin
      logic [COORD_W-1:0] ty;
      ty = COORD_W'($urandom_range(16, 1000));
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tbl_valid[e] = ($urandom_range(0, 9) < 7);
        tbl_id[e]    = 4'($urandom);
        tbl_or[e]    = 2'($urandom);
        tbl_x[e]     = ($urandom_range(0, 3) == 0) ? COORD_W'($urandom_range(1016, 1023))
                                                   : COORD_W'($urandom);
        tbl_y[e]     = COORD_W'(int'(ty) + 3 - int'($urandom_range(0, 11)));
      end
      pixel_valid = 1'b0;
      apply_stimulus(ty);
      if ($urandom_range(0, 4) == 0) begin
        for (int i = int'($urandom_range(0, 6)); i > 0; i--) tick();
        apply_stimulus(ty);
      end
      wait_done();
      for (int i = 0; i < 24; i++) begin
        pixel_x     = COORD_W'(int'(tbl_x[$urandom_range(0, NUM_ENTRIES - 1)]) + int'($urandom_range(0, 11)) - 2);
        pixel_valid = ($urandom_range(0, 9) < 8);
        tick();
      end
    end

    pixel_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
Downstream consumer of the sprite ROM. In horizontal blanking it scans the entity table and selects the sprites that intersect the next scanline. For each selected sprite it drives the ROM's read_enable/orientation/sprite_ID/line_index and captures the returned 8-bit active-low row into a slot buffer. During active video it turns pixel_x into a per-pixel sprite hit and sprite ID for the pixel mixer.

Parameters:
NUM_ENTRIES, 8, entity table depth scanned per line (power of 2, ≥2)
NUM_SLOTS, 4, max sprites rendered on one scanline
COORD_W, 10, width of x/y coordinates

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
line_start  in  1  one-cycle pulse at hblank start; begins fetch for target_y
target_y  in  COORD_W  scanline about to be displayed; sampled on line_start
entry_index  out  log2(NUM_ENTRIES)  table read address; table answers combinationally in the same cycle
entry_valid  in  1  entry holds a live sprite
entry_sprite_ID  in  4  sprite ID
entry_orientation  in  2  UP=0, RIGHT=1, DOWN=2, LEFT=3
entry_x  in  COORD_W  left edge of the 8x8 sprite
entry_y  in  COORD_W  top edge of the 8x8 sprite
rom_read_enable  out  1  ROM read strobe
rom_orientation  out  2  passed through from the entry
rom_sprite_ID  out  4  passed through from the entry
rom_line_index  out  3  row within the sprite
rom_data  in  8  combinational ROM row, active-low, MSB = leftmost pixel
pixel_x  in  COORD_W  current pixel column
pixel_valid  in  1  active video
pixel_on  out  1  registered: a sprite pixel is lit
pixel_sprite_ID  out  4  registered: ID of the winning sprite
fetch_done  out  1  slot buffer is ready for the line
overflow  out  1  more than NUM_SLOTS hits on this line (sticky until next line_start)

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all slots invalid; entry_index=0; rom_read_enable=0; pixel_on=0; pixel_sprite_ID=0; fetch_done=0; overflow=0.
- FSM: IDLE -> FETCH on line_start. FETCH -> DONE after entry NUM_ENTRIES-1 is processed. DONE -> FETCH on line_start.
- line_start in FETCH or DONE restarts the fetch. line_start clears all slots, fetch_done and overflow, and latches target_y.
- FETCH takes exactly NUM_ENTRIES cycles, one entry per cycle. entry_index counts 0..NUM_ENTRIES-1.
- Hit test, combinational in the same cycle: row = target_y - entry_y (COORD_W-bit, modulo). hit = entry_valid && row < 8.
- ROM drive: rom_read_enable = FETCH && hit; rom_line_index = row[2:0]; orientation and ID are passed straight through. When not reading: rom_read_enable=0 and the other ROM outputs are 0.
- Capture: on the clock edge ending a hit cycle, rom_data, entry_x and entry_sprite_ID are written into the lowest free slot and the slot is marked valid.
- Slots fill in entry order, so slot 0 always holds the lowest-index hit.
- Hit when all slots are full: sprite is dropped, overflow set to 1.
- fetch_done goes to 1 in the cycle after the last entry and holds until the next line_start or reset.
- Pixel stage, one-cycle latency: outputs at cycle N+1 reflect pixel_x/pixel_valid at cycle N.
- Per slot: col = pixel_x - slot_x, computed at COORD_W+1 bits with no wrap. slot_hit = valid && pixel_x ≥ slot_x && col < 8 && bitmap[7-col]==0.
- Sprites extending past 2^COORD_W-1 are clipped.
- Priority: the lowest slot index wins. pixel_sprite_ID = winner ID, or 0 if no slot hits.
- pixel_on is forced to 0 when pixel_valid=0 or fetch_done=0.
- Entry outside its own 8 rows (row ≥ 8, including target_y < entry_y) is a miss; no ROM read is issued.

Decomposition:
- Shared package holds: orientation constants UP/RIGHT/DOWN/LEFT, SPRITE_SIZE=8, sprite ID width 4, COORD_W default.
- One sub-module: sprite_slot. It owns one slot's registers (valid, x, ID, bitmap), the load/clear controls, and the combinational slot_hit. It is instantiated NUM_SLOTS times.
- The top level keeps the FSM, the fetch counter, slot allocation, the priority encoder and the output registers.

Test Plan:
- Heart (ID 0, UP) at x=100, y=50, ROM row1=10011001; line_start with target_y=51 -> rom_read_enable for 1 cycle with line_index=1. Then pixel_x=100 -> pixel_on=0 next cycle; pixel_x=101 -> pixel_on=1, ID=0; pixel_x=108 -> pixel_on=0.
- Entry at y=50; target_y=49 and target_y=58 -> no ROM read issued, all pixels off. target_y=57 -> line_index=7.
- 5 valid entries all hitting target_y with NUM_SLOTS=4 -> slots hold entries 0..3, entry 4 dropped, overflow=1. fetch_done asserts exactly NUM_ENTRIES+1 cycles after line_start.
- Overlap: entry 2 (ID 1) and entry 5 (ID 7) at the same x, both pixels lit -> pixel_sprite_ID=1.
- line_start pulsed again mid-FETCH at entry 3 -> entry_index restarts at 0, slots cleared, fetch_done=0 until the full NUM_ENTRIES cycles elapse.
- reset asserted during DONE with a sprite under pixel_x -> pixel_on=0 and fetch_done=0 immediately (asynchronous). After release, pixel_on stays 0 until the next completed fetch.
